// File: rtl/sar_pkg.sv
// Shared state encoding for the successive-approximation search controller.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } sar_state_t;

endpackage

// File: rtl/comparator.sv
// Combinational magnitude comparator: exactly one of lt/eq/gt is high.
module comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    // Relation of a to b
    always_comb begin
        lt = (a < b);
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives trial values to an
// external comparator and resolves the target one bit per clock, MSB first,
// exiting early on an exact match.
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             lt,
    input  logic             eq,
    input  logic             gt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             fault
);

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB = {{(WIDTH-1){1'b0}}, 1'b1};

    sar_state_t       state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] mask, mask_n;
    logic [WIDTH-1:0] result_n;
    logic             fault_n;
    logic [WIDTH-1:0] acc_upd;

    // Outputs derive from registers only: no input-to-output path
    assign trial = acc | mask;
    assign busy  = (state == TEST);
    assign done  = (state == DONE);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mask   <= '0;
            result <= '0;
            fault  <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            mask   <= mask_n;
            result <= result_n;
            fault  <= fault_n;
        end
    end

    // Next-state and datapath update; flags are judged against the current trial
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        mask_n   = mask;
        result_n = result;
        fault_n  = fault;
        acc_upd  = acc;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_n   = '0;
                    mask_n  = MSB;
                    fault_n = 1'b0;
                    state_n = TEST;
                end
            end
            TEST: begin
                case ({lt, eq, gt})
                    3'b010: begin
                        result_n = trial;
                        state_n  = DONE;
                    end
                    3'b100, 3'b001: begin
                        // lt keeps the test bit, gt drops it
                        if (lt) begin
                            acc_upd = trial;
                        end
                        acc_n = acc_upd;
                        if (mask == LSB) begin
                            result_n = acc_upd;
                            state_n  = DONE;
                        end else begin
                            mask_n = mask >> 1;
                        end
                    end
                    default: begin
                        fault_n  = 1'b1;
                        result_n = acc;
                        state_n  = DONE;
                    end
                endcase
            end
            DONE: begin
                mask_n  = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed self-checking bench for sar_search closed around a comparator.
module tb_sar_search;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] target;
    logic             force_bad;
    logic             cmp_lt, cmp_eq, cmp_gt;
    logic             lt, eq, gt;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             fault;

    int checks = 0;
    int passed = 0;
    logic [WIDTH-1:0] tr [0:15];

    comparator #(.WIDTH(WIDTH)) u_cmp (
        .a  (trial),
        .b  (target),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    // force_bad makes lt and gt both high (invalid flag set)
    assign lt = cmp_lt | force_bad;
    assign gt = cmp_gt | force_bad;
    assign eq = cmp_eq & ~force_bad;

    sar_search #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .lt     (lt),
        .eq     (eq),
        .gt     (gt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .fault  (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runs one search; c counts cycles after the start edge (c=1 is TEST 1)
    task automatic search(input logic [WIDTH-1:0] tgt, input int fault_at, input int pulse_at,
                          output int ntr, output int done_cyc, output int dones);
        @(negedge clk);
        target = tgt;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        ntr      = 0;
        done_cyc = 0;
        dones    = 0;
        for (int c = 1; c <= 40; c++) begin
            force_bad = 1'b0;
            start     = (c == pulse_at);
            if (busy) begin
                if (ntr < 16) tr[ntr] = trial;
                ntr++;
                if (ntr == fault_at) force_bad = 1'b1;
            end
            if (done) begin
                dones++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (done_cyc != 0 && c > done_cyc + 1) break;
            @(negedge clk);
        end
        force_bad = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; target = '0; force_bad = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (trial !== 8'h00) $display("FAIL reset_trial: got %h expected 00", trial); else passed++;
        checks++; if ({busy, done, fault} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, done, fault}); else passed++;
        checks++; if (result !== 8'h00) $display("FAIL reset_result: got %h expected 00", result); else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done, trial} !== 10'd0) $display("FAIL idle_after_reset: got %b expected 0", {busy, done, trial}); else passed++;
    endtask

    task automatic test_search_5a();
        logic [WIDTH-1:0] exp_tr [0:6];
        int ntr, dc, dn;
        exp_tr = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
        search(8'h5A, 0, 0, ntr, dc, dn);
        for (int i = 0; i < 7; i++) begin
            checks++; if (tr[i] !== exp_tr[i]) $display("FAIL s5a_trial%0d: got %h expected %h", i, tr[i], exp_tr[i]); else passed++;
        end
        checks++; if (ntr !== 7) $display("FAIL s5a_tests: got %0d expected 7", ntr); else passed++;
        checks++; if (dc !== 8) $display("FAIL s5a_done_cycle: got %0d expected 8", dc); else passed++;
        checks++; if (dn !== 1) $display("FAIL s5a_done_pulses: got %0d expected 1", dn); else passed++;
        checks++; if (result !== 8'h5A) $display("FAIL s5a_result: got %h expected 5a", result); else passed++;
        checks++; if (fault !== 1'b0) $display("FAIL s5a_fault: got %b expected 0", fault); else passed++;
    endtask

    task automatic test_search_zero();
        logic [WIDTH-1:0] e;
        int ntr, dc, dn;
        search(8'h00, 0, 0, ntr, dc, dn);
        for (int i = 0; i < 8; i++) begin
            e = 8'h80 >> i;
            checks++; if (tr[i] !== e) $display("FAIL s00_trial%0d: got %h expected %h", i, tr[i], e); else passed++;
        end
        checks++; if (ntr !== 8) $display("FAIL s00_tests: got %0d expected 8", ntr); else passed++;
        checks++; if (dc !== 9) $display("FAIL s00_done_cycle: got %0d expected 9", dc); else passed++;
        checks++; if (result !== 8'h00) $display("FAIL s00_result: got %h expected 00", result); else passed++;
    endtask

    task automatic test_search_ff();
        logic [WIDTH-1:0] e;
        int ntr, dc, dn;
        search(8'hFF, 0, 0, ntr, dc, dn);
        for (int i = 0; i < 8; i++) begin
            e = ~(8'hFF >> (i + 1));
            checks++; if (tr[i] !== e) $display("FAIL sff_trial%0d: got %h expected %h", i, tr[i], e); else passed++;
        end
        checks++; if (ntr !== 8) $display("FAIL sff_tests: got %0d expected 8", ntr); else passed++;
        checks++; if (dc !== 9) $display("FAIL sff_done_cycle: got %0d expected 9", dc); else passed++;
        checks++; if (result !== 8'hFF) $display("FAIL sff_result: got %h expected ff", result); else passed++;
    endtask

    task automatic test_fault();
        int ntr, dc, dn;
        search(8'h5A, 3, 0, ntr, dc, dn);
        checks++; if (fault !== 1'b1) $display("FAIL flt_fault: got %b expected 1", fault); else passed++;
        checks++; if (result !== 8'h40) $display("FAIL flt_result: got %h expected 40", result); else passed++;
        checks++; if (dn !== 1) $display("FAIL flt_done_pulses: got %0d expected 1", dn); else passed++;
        checks++; if (dc !== 4) $display("FAIL flt_done_cycle: got %0d expected 4", dc); else passed++;
        search(8'h5A, 0, 0, ntr, dc, dn);
        checks++; if (fault !== 1'b0) $display("FAIL flt_cleared: got %b expected 0", fault); else passed++;
        checks++; if (result !== 8'h5A) $display("FAIL flt_next_result: got %h expected 5a", result); else passed++;
    endtask

    task automatic test_restart_ignored();
        int ntr, dc, dn;
        search(8'hA5, 0, 3, ntr, dc, dn);
        checks++; if (result !== 8'hA5) $display("FAIL rst_ign_result: got %h expected a5", result); else passed++;
        checks++; if (ntr !== 8) $display("FAIL rst_ign_tests: got %0d expected 8", ntr); else passed++;
        checks++; if (dc !== 9) $display("FAIL rst_ign_done_cycle: got %0d expected 9", dc); else passed++;
        checks++; if (dn !== 1) $display("FAIL rst_ign_done_pulses: got %0d expected 1", dn); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_ign_idle: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        int ntr, dc, dn;
        int seen_done;
        @(negedge clk);
        target = 8'h5A;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL rmid_busy_before: got %b expected 1", busy); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (trial !== 8'h00) $display("FAIL rmid_trial: got %h expected 00", trial); else passed++;
        checks++; if ({busy, done, fault} !== 3'b000) $display("FAIL rmid_flags: got %b expected 000", {busy, done, fault}); else passed++;
        checks++; if (result !== 8'h00) $display("FAIL rmid_result: got %h expected 00", result); else passed++;
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++; if (seen_done !== 0) $display("FAIL rmid_no_done: got %0d expected 0", seen_done); else passed++;
        search(8'h33, 0, 0, ntr, dc, dn);
        checks++; if (result !== 8'h33) $display("FAIL rmid_next_result: got %h expected 33", result); else passed++;
        checks++; if (dc !== 9) $display("FAIL rmid_next_done_cycle: got %0d expected 9", dc); else passed++;
    endtask

    task automatic test_back_to_back();
        int d1, d2, dones;
        logic [WIDTH-1:0] r1, r2, t2_trial;
        logic idle_busy, t2_busy;
        d1 = 0; d2 = 0; dones = 0;
        r1 = '0; r2 = '0; t2_trial = '0; idle_busy = 1'b1; t2_busy = 1'b0;
        @(negedge clk);
        target = 8'h11;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                dones++;
                if (d1 == 0) begin
                    d1 = c; r1 = result; target = 8'hEE;
                end else if (d2 == 0) begin
                    d2 = c; r2 = result; start = 1'b0;
                end
            end
            if (d1 != 0 && c == d1 + 1) idle_busy = busy;
            if (d1 != 0 && c == d1 + 2) begin
                t2_busy = busy; t2_trial = trial;
            end
            if (d2 != 0 && c >= d2 + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (d1 !== 9) $display("FAIL b2b_done1_cycle: got %0d expected 9", d1); else passed++;
        checks++; if (r1 !== 8'h11) $display("FAIL b2b_result1: got %h expected 11", r1); else passed++;
        checks++; if (idle_busy !== 1'b0) $display("FAIL b2b_idle_gap: got %b expected 0", idle_busy); else passed++;
        checks++; if ({t2_busy, t2_trial} !== {1'b1, 8'h80}) $display("FAIL b2b_second_start: got %b/%h expected 1/80", t2_busy, t2_trial); else passed++;
        checks++; if (d2 !== 18) $display("FAIL b2b_done2_cycle: got %0d expected 18", d2); else passed++;
        checks++; if (r2 !== 8'hEE) $display("FAIL b2b_result2: got %h expected ee", r2); else passed++;
        checks++; if (dones !== 2) $display("FAIL b2b_done_pulses: got %0d expected 2", dones); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_final_idle: got %b expected 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_search_5a();
        test_search_zero();
        test_search_ff();
        test_fault();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller: the driving side of a magnitude comparator. It drives a trial value onto a comparator's `a` input, with the unknown target on `b`. It reads back `lt`/`eq`/`gt` and resolves the target one bit per clock, MSB first, stopping early when it sees an exact match. It sits beside a `comparator` instance of matching WIDTH and is used for threshold search and for learning FSM simulation workflows.

## Interface
- `WIDTH`, default 8: trial, result and target width in bits (≥2).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a search; sampled only in IDLE.
- `lt`  in  1  comparator: trial < target.
- `eq`  in  1  comparator: trial == target.
- `gt`  in  1  comparator: trial > target.
- `trial`  out  WIDTH  value presented to comparator `a`.
- `busy`  out  1  high while searching.
- `done`  out  1  one-cycle pulse when a search ends.
- `result`  out  WIDTH  resolved target; held until the next start.
- `fault`  out  1  comparator flags were invalid during the last search; sticky until the next start.

## Operation
- Registers:
  - `acc`: WIDTH bits, the accepted bits.
  - `mask`: WIDTH bits, one-hot test bit, or zero.
  - state.
- `trial = acc | mask`. It is combinational from registers only, with no input-to-output path.
- Reset values:
  - state = IDLE.
  - `acc` = 0, `mask` = 0, so `trial` = 0.
  - `busy` = 0, `done` = 0, `result` = 0, `fault` = 0.
- IDLE:
  - `start`=1 → `acc`←0, `mask`←1<<(WIDTH-1), `fault`←0, go to TEST.
- TEST (`busy`=1). Each cycle, sample the flags against the current `trial`:
  - Invalid flags, meaning not exactly one of `lt`/`eq`/`gt` high → `fault`←1, `result`←`acc`, go to DONE.
  - `eq` → `result`←`trial`, go to DONE (early exit).
  - `lt` → `acc`←`trial` (keep the bit).
  - `gt` → `acc` unchanged (drop the bit).
  - For `lt`/`gt`: if `mask`==1, then `result`←`acc` after update, go to DONE; otherwise `mask`←`mask`>>1.
- DONE:
  - `done`=1 and `busy`=0 for exactly one cycle.
  - `mask`←0, so `trial` = `acc`.
  - Go to IDLE.
- Arithmetic: bitwise OR and shift only, with no carries. `result` is always within 0..2^WIDTH-1.
- `start` in TEST or DONE is ignored; it is not queued.
- `reset` mid-search aborts immediately to reset values. No `done` pulse is produced.
- Target 0 never produces `eq`. It resolves through the all-`gt` path to `result`=0 after WIDTH tests.

## Timing
- `start` is sampled high at edge k; TEST cycles begin at k+1.
- Worst case: WIDTH TEST cycles, `done` high in cycle k+WIDTH+1, and `start` accepted again at edge k+WIDTH+2.
- Early exit on `eq` in TEST cycle n (1..WIDTH) gives `done` in cycle k+n+1.
- The comparator is combinational. Flags are sampled in the same cycle the `trial` is presented, so a zero-latency external path is required.
- `result` updates on the edge entering DONE. It is valid while `done`=1 and stable until the next accepted `start`.
- `busy` is high exactly during the TEST cycles.

## Structure
- Package `sar_pkg` holds the state enum (IDLE, TEST, DONE). No other shared constants.
- Single flat module with no RTL sub-module. The bench instantiates `comparator #(WIDTH)` with `a`=`trial` and `b`=the bench target, closing the loop.

## Test plan
- Target 0x5A, WIDTH=8, pulse `start`:
  - trials 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A;
  - `eq` on the 7th test, `done` 8 cycles after `start`, `result`=0x5A, `fault`=0.
- Target 0x00: trials 0x80..0x01 all `gt`, 8 tests, `result`=0x00, `done` 9 cycles after `start`.
- Target 0xFF: trials 0x80,0xC0,…,0xFE `lt`, then 0xFF `eq` on test 8, `result`=0xFF.
- Bench forces `lt`=`gt`=1 on test 3 of target 0x5A: `fault`=1, `result`=0x40, `done` pulses once, and `fault` clears on the next `start`.
- `start` re-pulsed mid-search is ignored and the result is unchanged.
- `reset` asserted on test 4: outputs immediately return to zero with no `done` pulse. A new search for 0x33 then yields `result`=0x33.
- Back-to-back: `start` held high continuously over targets 0x11 then 0xEE gives two searches, each with a single `done` pulse and correct `result`. The second search starts the cycle after DONE.
